y86_regfile: RTL
================

Name: y86_regfile

Overview:
- Y86-64 architectural register file, the consumer of the srcA/srcB/dstE/dstM register IDs produced by the decode-stage register-selection logic.
- Provides two combinational read ports (A, B) and two synchronous write ports: E carries the ALU result, M carries the memory load result.
- Register ID 4'hF (NonReg) on any port means "no register": reads return 0 and writes are dropped.
- Also provides a debug read port and a write-back commit gate driven by the processor status.

Parameters:
- DATA_WID, 64, register width in bits.
- ADDR_WID, 4, register ID width; IDs 0..14 are real registers, 15 is NonReg.
- BYPASS, 1, when 1 a same-cycle write is forwarded to the read ports (write-before-read); when 0 reads return the pre-write value.
- RSP_INIT, 0, reset value of register 4 (%rsp); all other registers reset to 0.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- srcA  in  ADDR_WID  read port A register ID
- srcB  in  ADDR_WID  read port B register ID
- valA  out  DATA_WID  read data A
- valB  out  DATA_WID  read data B
- dstE  in  ADDR_WID  E-port destination ID
- valE  in  DATA_WID  E-port write data
- dstM  in  ADDR_WID  M-port destination ID
- valM  in  DATA_WID  M-port write data
- wb_en  in  1  write-back commit; when 0, both write ports are ignored (bubble or non-AOK status)
- dbg_addr  in  ADDR_WID  debug read ID
- dbg_data  out  DATA_WID  debug read data; never bypassed
- wr_count  out  16  count of committed register writes; saturates at 16'hFFFF

Behaviour:
- Storage: 15 registers of DATA_WID bits, indices 0..14. No storage exists for ID 15.
- Reset (rst=1 at a rising clk edge):
  - All registers clear to 0, except register 4, which loads RSP_INIT.
  - wr_count clears to 0.
  - Any writes presented in the same cycle are discarded.
- Reset during active writes: reset wins; the write of that cycle has no effect.
- Writes occur on the rising clk edge when rst=0 and wb_en=1:
  - E port: if dstE != 4'hF, reg[dstE] <= valE.
  - M port: if dstM != 4'hF, reg[dstM] <= valM.
  - Collision (dstE == dstM != 4'hF): the M port wins and reg gets valM. This is the popq %rsp case.
- wr_count adds the number of ports that actually wrote in the cycle (0, 1 or 2); a collision counts as 1.
  - It saturates at 16'hFFFF and never wraps.
- Reads are combinational with zero latency:
  - srcX == 4'hF returns valX = 0.
  - BYPASS=1: if wb_en=1 and rst=0, valX uses priority dstM match -> valM, then dstE match -> valE, then stored value. A NonReg dst never matches.
  - BYPASS=0: valX returns the stored value; new data is visible from the cycle after the write.
  - While rst=1, reads return stored (pre-reset) values without bypass; reset values are visible from the following cycle.
- dbg_data is a combinational read of the stored value only; dbg_addr 15 returns 0.
- Out-of-range IDs cannot occur because 15 is the only unused encoding; no other error handling is required.
- No X propagation: every output is driven from defined storage or a constant in every cycle after the first reset.

Test Plan:
- Reset with RSP_INIT=64'h100 -> dbg_data reads 64'h100 at ID 4 and 0 at IDs 0..3 and 5..14; wr_count=0.
- dstE=2, valE=64'hDEAD, wb_en=1, srcA=2, BYPASS=1 -> valA=64'hDEAD in the same cycle; with BYPASS=0, valA=0 that cycle and 64'hDEAD the next; wr_count=1.
- dstE=4, valE=64'h108, dstM=4, valM=64'h55, wb_en=1 -> reg4=64'h55 after the edge; same-cycle srcB=4 bypass returns 64'h55; wr_count increments by 1.
- dstE=3, valE=7, dstM=5, valM=9, wb_en=0 -> no change, reg3 and reg5 keep their old values, wr_count unchanged. Repeat with wb_en=1 -> reg3=7, reg5=9, wr_count +2.
- dstE=dstM=4'hF, srcA=srcB=dbg_addr=4'hF, wb_en=1 -> valA=valB=dbg_data=0, no register changes, wr_count unchanged.
- Preload wr_count to 16'hFFFE via 2-write cycles, issue one more 2-write cycle -> wr_count=16'hFFFF and stays there. Assert rst in the same cycle as a write to reg1 -> reg1=0 and wr_count=0 afterward.

Source files
------------

// File: rtl/y86_regfile_if.sv
// y86_regfile_if: bundle of the register-file data-path signals.
//   master : decode/write-back side (drives IDs, write data, commit, debug ID)
//   slave  : the register file (returns read data, debug data, write count)
interface y86_regfile_if #(
    parameter int DATA_WID = 64,
    parameter int ADDR_WID = 4
);
    logic [ADDR_WID-1:0] srcA;
    logic [ADDR_WID-1:0] srcB;
    logic [DATA_WID-1:0] valA;
    logic [DATA_WID-1:0] valB;
    logic [ADDR_WID-1:0] dstE;
    logic [DATA_WID-1:0] valE;
    logic [ADDR_WID-1:0] dstM;
    logic [DATA_WID-1:0] valM;
    logic                wb_en;
    logic [ADDR_WID-1:0] dbg_addr;
    logic [DATA_WID-1:0] dbg_data;
    logic [15:0]         wr_count;

    modport master (
        output srcA, srcB, dstE, valE, dstM, valM, wb_en, dbg_addr,
        input  valA, valB, dbg_data, wr_count
    );

    modport slave (
        input  srcA, srcB, dstE, valE, dstM, valM, wb_en, dbg_addr,
        output valA, valB, dbg_data, wr_count
    );
endinterface

// File: rtl/y86_regfile.sv
// y86_regfile: Y86-64 architectural register file.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : y86_regfile_if.slave
//              srcA/srcB -> valA/valB   combinational reads (optional bypass)
//              dstE/valE, dstM/valM     write ports, committed when wb_en=1
//              dbg_addr -> dbg_data     stored-value read, never bypassed
//              wr_count                 saturating count of committed writes
// ID 4'hF (NonReg) reads as 0 and is never written.

// One read port: NonReg gating plus same-cycle forwarding from the write ports.
module y86_regfile_rd #(
    parameter int DATA_WID = 64,
    parameter int ADDR_WID = 4,
    parameter bit BYPASS   = 1'b1
) (
    input  logic [ADDR_WID-1:0] src,
    input  logic [DATA_WID-1:0] stored,
    input  logic                byp_en,
    input  logic [ADDR_WID-1:0] dstE,
    input  logic [DATA_WID-1:0] valE,
    input  logic [ADDR_WID-1:0] dstM,
    input  logic [DATA_WID-1:0] valM,
    output logic [DATA_WID-1:0] val
);
    localparam logic [ADDR_WID-1:0] NONREG = '1;

    always_comb begin
        val = stored;
        if (src == NONREG) begin
            val = '0;
        end else if (BYPASS && byp_en) begin
            // src is a real register here, so a NonReg dst can never match.
            // M before E mirrors the collision rule on the write side.
            if (dstM == src)      val = valM;
            else if (dstE == src) val = valE;
        end
    end
endmodule

module y86_regfile #(
    parameter int                 DATA_WID = 64,
    parameter int                 ADDR_WID = 4,
    parameter bit                 BYPASS   = 1'b1,
    parameter logic [DATA_WID-1:0] RSP_INIT = '0
) (
    input logic          clk,
    input logic          rst,
    y86_regfile_if.slave bus
);
    localparam int                  NUM_REGS = (1 << ADDR_WID) - 1;
    localparam int                  NUM_RD   = 2;
    localparam logic [ADDR_WID-1:0] NONREG   = '1;

    logic [DATA_WID-1:0] regs [NUM_REGS];
    logic [15:0]         cnt;

    logic                e_wr, m_wr, e_eff;
    logic [1:0]          n_wr;
    logic [16:0]         cnt_sum;

    assign e_wr  = bus.wb_en && (bus.dstE != NONREG);
    assign m_wr  = bus.wb_en && (bus.dstM != NONREG);
    // On a collision only M lands, so E does not count as a separate write.
    assign e_eff = e_wr && !(m_wr && (bus.dstE == bus.dstM));
    assign n_wr  = {1'b0, e_eff} + {1'b0, m_wr};
    assign cnt_sum = {1'b0, cnt} + 17'(n_wr);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= (i == 4) ? RSP_INIT : '0;
            cnt <= '0;
        end else begin
            // M is assigned last so it wins when both target one register.
            if (e_wr) regs[bus.dstE] <= bus.valE;
            if (m_wr) regs[bus.dstM] <= bus.valM;
            cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
        end
    end

    assign bus.wr_count = cnt;
    assign bus.dbg_data = (bus.dbg_addr == NONREG) ? '0 : regs[bus.dbg_addr];

    // Read lanes: port 0 = A, port 1 = B.
    logic [NUM_RD-1:0][ADDR_WID-1:0] rd_src;
    logic [NUM_RD-1:0][DATA_WID-1:0] rd_stored;
    logic [NUM_RD-1:0][DATA_WID-1:0] rd_val;
    logic                            byp_en;

    // Reset suppresses forwarding: reads during rst show pre-reset storage.
    assign byp_en = bus.wb_en && !rst;
    assign rd_src = {bus.srcB, bus.srcA};

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        assign rd_stored[g] = (rd_src[g] == NONREG) ? '0 : regs[rd_src[g]];

        y86_regfile_rd #(
            .DATA_WID(DATA_WID),
            .ADDR_WID(ADDR_WID),
            .BYPASS  (BYPASS)
        ) u_rd (
            .src   (rd_src[g]),
            .stored(rd_stored[g]),
            .byp_en(byp_en),
            .dstE  (bus.dstE),
            .valE  (bus.valE),
            .dstM  (bus.dstM),
            .valM  (bus.valM),
            .val   (rd_val[g])
        );
    end

    assign bus.valA = rd_val[0];
    assign bus.valB = rd_val[1];
endmodule
